// File: rtl/axis_bram_adapter_v1_0_pkg.sv
// Shared constants for the BRAM adapter scheduler: FSM encoding, transfer
// direction codes and the default BRAM word-index width.
package axis_bram_adapter_v1_0_pkg;

  localparam int DEFAULT_ADDR_W = 9;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/axis_bram_adapter_v1_0_rr_arb.sv
// Two-way round-robin arbiter: req[0] = write client, req[1] = read client.
// The pointer favours the client that was not served last.
module axis_bram_adapter_v1_0_rr_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last_rd,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= 1'b0;
    end else if (update) begin
      rr_ptr <= ~last_rd;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axis_bram_adapter_v1_0_sched.sv
// Shares one adapter controller between a write and a read client: range-checks
// each descriptor, launches it, and waits for done under a watchdog.
module axis_bram_adapter_v1_0_sched
  import axis_bram_adapter_v1_0_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_start,
  input  logic [ADDR_W-1:0] wr_end,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_start,
  input  logic [ADDR_W-1:0] rd_end,
  output logic              rd_ack,
  output logic              rd_err,
  output logic              cntl_rw,
  output logic [ADDR_W-1:0] cntl_index,
  output logic [ADDR_W-1:0] cntl_size,
  output logic              cntl_start,
  output logic              cntl_abort,
  input  logic              cntl_done,
  output logic              busy,
  output logic              grant_rd
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state;
  logic                 err;
  logic [TIMEOUT_W-1:0] watchdog;
  logic [1:0]           grant;
  logic                 wd_expired;

  axis_bram_adapter_v1_0_rr_arb u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({rd_req, wr_req}),
    .update  (state == ST_RESP),
    .last_rd (grant_rd),
    .grant   (grant)
  );

  // The latched descriptor doubles as the controller command, so it is
  // naturally stable from ISSUE through WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      err        <= 1'b0;
      watchdog   <= '0;
      cntl_rw    <= RW_READ;
      cntl_index <= '0;
      cntl_size  <= '0;
      grant_rd   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            cntl_index <= grant[1] ? rd_start : wr_start;
            cntl_size  <= grant[1] ? rd_end   : wr_end;
            cntl_rw    <= grant[1] ? RW_READ  : RW_WRITE;
            grant_rd   <= grant[1];
            err        <= 1'b0;
            state      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cntl_size < cntl_index) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          watchdog <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          watchdog <= watchdog + TIMEOUT_W'(1);
          if (cntl_done) begin
            err   <= 1'b0;
            state <= ST_RESP;
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A done on the timeout cycle wins, so abort is suppressed by cntl_done.
  assign wd_expired = (watchdog == WD_LAST);
  assign cntl_abort = (state == ST_WAIT) && wd_expired && !cntl_done;
  assign cntl_start = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign wr_ack     = (state == ST_RESP) && !grant_rd;
  assign rd_ack     = (state == ST_RESP) && grant_rd;
  assign wr_err     = wr_ack && err;
  assign rd_err     = rd_ack && err;

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// Scoreboard bench for the scheduler: directed descriptors push expected
// controller/ack events; a negedge monitor pops and compares them.
module tb_axis_bram_adapter_v1_0_sched;

  localparam int AW = 9;
  localparam int TW = 16;
  localparam int TO = 64;

  typedef enum int {EV_START, EV_ABORT, EV_WR_ACK, EV_RD_ACK} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [19:0] payload;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_start = '0;
  logic [AW-1:0] wr_end = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_start = '0;
  logic [AW-1:0] rd_end = '0;
  logic          cntl_done = 1'b0;
  logic          wr_ack, wr_err, rd_ack, rd_err;
  logic          cntl_rw, cntl_start, cntl_abort, busy, grant_rd;
  logic [AW-1:0] cntl_index, cntl_size;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_delay = -1;
  int   spurious_at = -1;
  int   r;

  axis_bram_adapter_v1_0_sched #(
    .ADDR_W(AW), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_req(wr_req), .wr_start(wr_start), .wr_end(wr_end),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_req(rd_req), .rd_start(rd_start), .rd_end(rd_end),
    .rd_ack(rd_ack), .rd_err(rd_err),
    .cntl_rw(cntl_rw), .cntl_index(cntl_index), .cntl_size(cntl_size),
    .cntl_start(cntl_start), .cntl_abort(cntl_abort), .cntl_done(cntl_done),
    .busy(busy), .grant_rd(grant_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void pushExp(input ev_kind_t k, input int c, input logic [19:0] pl);
    exp_t e;
    e.kind = k;
    e.cyc = c;
    e.payload = pl;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input bit is_rd, input logic [AW-1:0] s,
                               input logic [AW-1:0] e, output int rc);
    @(posedge clk);
    #1;
    if (is_rd) begin
      rd_start = s; rd_end = e; rd_req = 1'b1;
    end else begin
      wr_start = s; wr_end = e; wr_req = 1'b1;
    end
    rc = cyc;
  endtask

  // Client behaviour: hold req until ack is seen, then drop it.
  task automatic waitAck(input bit is_rd);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_rd ? rd_ack : wr_ack) begin
        if (is_rd) rd_req = 1'b0; else wr_req = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s_ack_timeout: got no ack in 200 cycles, required ack", is_rd ? "rd" : "wr");
    if (is_rd) rd_req = 1'b0; else wr_req = 1'b0;
  endtask

  // Controller model: done arrives done_delay cycles after cntl_start.
  initial begin
    int  done_in;
    bit  start_now;
    done_in = -1;
    forever begin
      @(negedge clk);
      start_now = cntl_start;
      @(posedge clk);
      #1;
      cntl_done = 1'b0;
      if (!rstn) begin
        done_in = -1;
      end else begin
        if (start_now && done_delay > 0) begin
          done_in = done_delay - 1;
        end else if (done_in > 0) begin
          done_in--;
          if (done_in == 0) begin
            cntl_done = 1'b1;
            done_in = -1;
          end
        end
        if (cyc == spurious_at) cntl_done = 1'b1;
      end
    end
  end

  // Monitor: every observed event must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_kind_t    k;
    logic [19:0] pl;
    exp_t        e;
    for (int t = 0; t < 4; t++) begin
      bit hit;
      hit = 1'b0;
      pl = '0;
      k = EV_START;
      case (t)
        0: if (cntl_start) begin hit = 1; k = EV_START;  pl = {1'b0, cntl_rw, cntl_index, cntl_size}; end
        1: if (cntl_abort) begin hit = 1; k = EV_ABORT;  pl = {1'b1, cntl_rw, cntl_index, cntl_size}; end
        2: if (wr_ack)     begin hit = 1; k = EV_WR_ACK; pl = {wr_err, 19'd0}; end
        default: if (rd_ack) begin hit = 1; k = EV_RD_ACK; pl = {rd_err, 19'd0}; end
      endcase
      if (hit) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("event_kind_exp_cyc%0d", e.cyc), k, e.kind);
          checkOutput($sformatf("event_cycle_kind%0d", e.kind), cyc, e.cyc);
          checkOutput($sformatf("event_payload_kind%0d", e.kind), pl, e.payload);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, required finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {busy, grant_rd, cntl_rw, cntl_start, cntl_abort, wr_ack, wr_err,
                 rd_ack, rd_err, cntl_index, cntl_size}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Simultaneous pairs: write first every time, read on the cycle after wr_ack.
    done_delay = 5;
    for (int p = 0; p < 3; p++) begin
      @(posedge clk);
      #1;
      wr_start = 9'd1;   wr_end = 9'd4;   wr_req = 1'b1;
      rd_start = 9'd100; rd_end = 9'd200; rd_req = 1'b1;
      r = cyc;
      pushExp(EV_START,  r + 2,  {1'b0, 1'b1, 9'd1, 9'd4});
      pushExp(EV_WR_ACK, r + 8,  {1'b0, 19'd0});
      pushExp(EV_START,  r + 11, {1'b0, 1'b0, 9'd100, 9'd200});
      pushExp(EV_RD_ACK, r + 17, {1'b0, 19'd0});
      waitAck(1'b0);
      waitAck(1'b1);
    end

    // Single write 0..15, done 18 cycles after start.
    done_delay = 18;
    applyStimulus(1'b0, 9'd0, 9'd15, r);
    pushExp(EV_START,  r + 2,  {1'b0, 1'b1, 9'd0, 9'd15});
    pushExp(EV_WR_ACK, r + 21, {1'b0, 19'd0});
    waitAck(1'b0);

    // Reversed range is rejected without launching the controller.
    applyStimulus(1'b1, 9'd20, 9'd10, r);
    pushExp(EV_RD_ACK, r + 2, {1'b1, 19'd0});
    waitAck(1'b1);

    // No done at all: abort on the 64th WAIT cycle, then error ack.
    done_delay = -1;
    applyStimulus(1'b0, 9'd5, 9'd5, r);
    pushExp(EV_START,  r + 2,  {1'b0, 1'b1, 9'd5, 9'd5});
    pushExp(EV_ABORT,  r + 66, {1'b1, 1'b1, 9'd5, 9'd5});
    pushExp(EV_WR_ACK, r + 67, {1'b1, 19'd0});
    waitAck(1'b0);
    @(negedge clk);
    checkOutput("busy_after_timeout", busy, 0);

    // Full-BRAM read with done landing exactly on the timeout cycle.
    done_delay = TO;
    applyStimulus(1'b1, 9'd0, 9'd511, r);
    pushExp(EV_START,  r + 2,  {1'b0, 1'b0, 9'd0, 9'd511});
    pushExp(EV_RD_ACK, r + 67, {1'b0, 19'd0});
    waitAck(1'b1);

    // Spurious done while idle must produce nothing.
    @(posedge clk);
    #1;
    spurious_at = cyc + 2;
    repeat (6) @(negedge clk);
    checkOutput("idle_after_spurious_done", busy, 0);

    // Reset during WAIT clears outputs immediately and drops the transfer.
    done_delay = -1;
    applyStimulus(1'b0, 9'd7, 9'd9, r);
    pushExp(EV_START, r + 2, {1'b0, 1'b1, 9'd7, 9'd9});
    repeat (5) @(posedge clk);
    #2;
    checkOutput("busy_in_wait", busy, 1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_outputs",
                {busy, grant_rd, cntl_rw, cntl_start, cntl_abort, wr_ack, wr_err,
                 rd_ack, rd_err, cntl_index, cntl_size}, 0);
    wr_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    done_delay = 4;
    applyStimulus(1'b0, 9'd3, 9'd8, r);
    pushExp(EV_START,  r + 2, {1'b0, 1'b1, 9'd3, 9'd8});
    pushExp(EV_WR_ACK, r + 7, {1'b0, 19'd0});
    waitAck(1'b0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
